// File: rtl/sequential_multiplier.sv
// Unsigned NxN shift-and-add multiplier: one add/shift per clock, 2N-bit product as two N-bit halves.
// Optional build macro SEQ_MULT_RESTART_EN: a start while busy restarts the operation with the current operands.
module sequential_multiplier #(
   parameter int N = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_b,
   input  logic         i_start,
   output logic [N-1:0] o_m,
   output logic [N-1:0] o_r,
   output logic         o_busy,
   output logic         o_valid
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_CALC = 1'b1;

   logic [0:0]    r_state;
   logic [N-1:0]  r_mc;
   logic [N:0]    r_acc;
   logic [N-1:0]  r_q;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_m;
   logic [N-1:0]  r_r;
   logic          r_busy;
   logic          r_valid;

   logic [N:0]    w_addend;
   logic [N:0]    w_sum;
   logic [N-1:0]  w_q_nxt;

   // The accumulator never exceeds N bits after a shift, so N+1 bits hold the add's carry
   assign w_addend = r_q[0] ? {1'b0, r_mc} : '0;
   assign w_sum    = r_acc + w_addend;
   assign w_q_nxt  = {w_sum[0], r_q[N-1:1]};

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_mc    <= '0;
         r_acc   <= '0;
         r_q     <= '0;
         r_cnt   <= '0;
         r_m     <= '0;
         r_r     <= '0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_mc    <= i_a;
                  r_q     <= i_b;
                  r_acc   <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_CALC;
               end
            end
            S_CALC: begin
`ifdef SEQ_MULT_RESTART_EN
               if (i_start) begin
                  r_mc  <= i_a;
                  r_q   <= i_b;
                  r_acc <= '0;
                  r_cnt <= '0;
               end else begin
`else
               begin
`endif
                  r_acc <= {1'b0, w_sum[N:1]};
                  r_q   <= w_q_nxt;
                  r_cnt <= r_cnt + CW'(1);
                  if (r_cnt == LAST) begin
                     r_m     <= w_sum[N:1];
                     r_r     <= w_q_nxt;
                     r_valid <= 1'b1;
                     r_busy  <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_m     = r_m;
   assign o_r     = r_r;
   assign o_busy  = r_busy;
   assign o_valid = r_valid;

endmodule

// File: tb/tb_sequential_multiplier.sv
// Directed bench for sequential_multiplier (N=4): table of products plus reset, start-while-busy and back-to-back sequences.
module tb_sequential_multiplier;

   localparam int N = 4;

   logic         clk;
   logic         rst;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         start;
   logic [N-1:0] m;
   logic [N-1:0] r;
   logic         busy;
   logic         valid;

   int total = 0;
   int bad   = 0;
   logic [N-1:0] held_m;
   logic [N-1:0] held_r;

   typedef struct {
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic [N-1:0] m;
      logic [N-1:0] r;
   } vec_t;

   vec_t vecs[7];

   sequential_multiplier #(.N(N)) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_a     (a),
      .i_b     (b),
      .i_start (start),
      .o_m     (m),
      .o_r     (r),
      .o_busy  (busy),
      .o_valid (valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive start at the current negedge; returns at the negedge after the accepting edge
   task automatic start_op(input logic [N-1:0] va, input logic [N-1:0] vb);
      a = va;
      b = vb;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a = N'($urandom);
      b = N'($urandom);
      chk("busy_after_start", busy, 1);
      chk("valid_after_start", valid, 0);
   endtask

   // Steps the remaining N edges; returns at the negedge where valid is expected high
   task automatic finish_op(input int remaining, input logic [N-1:0] em, input logic [N-1:0] er);
      for (int k = 1; k <= remaining; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (k < remaining) begin
            chk("busy_mid", busy, 1);
            chk("valid_mid", valid, 0);
            chk("m_held_mid", m, held_m);
            chk("r_held_mid", r, held_r);
         end
      end
      chk("valid_done", valid, 1);
      chk("busy_done", busy, 0);
      chk("m_done", m, em);
      chk("r_done", r, er);
      held_m = em;
      held_r = er;
   endtask

   initial begin
      vecs[0] = '{a: 4'b1010, b: 4'b0010, m: 4'b0001, r: 4'b0100};
      vecs[1] = '{a: 4'b1011, b: 4'b0011, m: 4'b0010, r: 4'b0001};
      vecs[2] = '{a: 4'b1111, b: 4'b1111, m: 4'b1110, r: 4'b0001};
      vecs[3] = '{a: 4'b0000, b: 4'b1101, m: 4'b0000, r: 4'b0000};
      vecs[4] = '{a: 4'b0001, b: 4'b1111, m: 4'b0000, r: 4'b1111};
      vecs[5] = '{a: 4'd7,    b: 4'd9,    m: 4'd3,    r: 4'd15};
      vecs[6] = '{a: 4'd12,   b: 4'd5,    m: 4'd3,    r: 4'd12};

      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      held_m = '0;
      held_r = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_m", m, 0);
      chk("rst_r", r, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valid", valid, 0);
      rst = 1'b0;
      @(negedge clk);

      // Each operation starts in the previous valid cycle, exercising back-to-back acceptance
      for (int i = 0; i < 7; i++) begin
         start_op(vecs[i].a, vecs[i].b);
         finish_op(N, vecs[i].m, vecs[i].r);
      end

      repeat (3) begin
         @(negedge clk);
         chk("idle_valid", valid, 0);
         chk("idle_busy", busy, 0);
         chk("idle_m_held", m, held_m);
         chk("idle_r_held", r, held_r);
      end

      // Reset two cycles into an operation
      start_op(4'b1010, 4'b0010);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", valid, 0);
      chk("midrst_m", m, 0);
      chk("midrst_r", r, 0);
      held_m = '0;
      held_r = '0;
      repeat (6) begin
         @(negedge clk);
         chk("midrst_no_valid", valid, 0);
      end
      start_op(4'b1011, 4'b0011);
      finish_op(N, 4'b0010, 4'b0001);

      @(negedge clk);
      // Second start during CALC
      start_op(4'b1010, 4'b0010);
      @(negedge clk);
      chk("busy_before_restart", busy, 1);
      a = 4'b1111;
      b = 4'b1111;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_2nd_start", busy, 1);
      chk("valid_after_2nd_start", valid, 0);
`ifdef SEQ_MULT_RESTART_EN
      finish_op(N, 4'b1110, 4'b0001);
`else
      finish_op(N - 2, 4'b0001, 4'b0100);
`endif
      @(negedge clk);
      chk("final_valid_low", valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
